// File: rtl/eth_mii_tx_framer_if.sv
// Packet-FIFO and MII transmit signal bundle for the framer.
// master = framer side, slave = FIFO/PHY side.
interface eth_mii_tx_framer_if;
  logic       Transmit_of_Data_RQ;
  logic [9:0] Data_to_Transmit;
  logic       Byte_Readed_Strob;
  logic       MII_Tx_CLK;
  logic       MII_Tx_En;
  logic [3:0] MII_Tx_Data;
  logic       Eth_Tx_In_Progress;
  logic       Frame_Sent;
  logic       Tx_Truncated;

  modport master (
    input  Transmit_of_Data_RQ, Data_to_Transmit, MII_Tx_CLK,
    output Byte_Readed_Strob, MII_Tx_En, MII_Tx_Data,
           Eth_Tx_In_Progress, Frame_Sent, Tx_Truncated
  );

  modport slave (
    output Transmit_of_Data_RQ, Data_to_Transmit, MII_Tx_CLK,
    input  Byte_Readed_Strob, MII_Tx_En, MII_Tx_Data,
           Eth_Tx_In_Progress, Frame_Sent, Tx_Truncated
  );
endinterface

// File: rtl/eth_mii_tx_framer.sv
// Byte FIFO to MII nibble stream: preamble/SFD, zero padding, CRC-32 FCS and
// inter-frame gap, all paced by a synchronised MII_Tx_CLK rising-edge tick.
module eth_mii_tx_framer #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 1514,
  parameter int IFG_NIBBLES     = 24
) (
  input  logic                System_Clock,
  input  logic                Reset,
  eth_mii_tx_framer_if.master tx
);
  localparam int                CNT_W    = $clog2((IFG_NIBBLES > 16) ? IFG_NIBBLES : 16);
  localparam logic [10:0]       MIN_CNT  = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0]       MAX_CNT  = 11'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0]  SFD_PREV = CNT_W'(14);
  localparam logic [CNT_W-1:0]  FCS_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0]  IFG_LAST = CNT_W'(IFG_NIBBLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DLO, S_DHI, S_PLO, S_PHI, S_FCS, S_IFG
  } state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  logic [2:0]       clk_sync_reg;
  logic             tick;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [10:0]      byte_cnt_reg, byte_cnt_next;
  logic [31:0]      crc_reg, crc_next;
  logic [8:0]       word_reg, word_next;
  logic             frame_end;
  logic [3:0]       fcs_nib [8];

  logic             tx_en_reg, tx_en_next;
  logic [3:0]       txd_reg, txd_next;
  logic             in_prog_reg, in_prog_next;
  logic             strobe_reg, strobe_next;
  logic             sent_reg, sent_next;
  logic             trunc_reg, trunc_next;

  // [1:0] is the synchroniser, [2] holds the previous synchronised level
  always_ff @(posedge System_Clock or posedge Reset) begin
    if (Reset) clk_sync_reg <= '0;
    else       clk_sync_reg <= {clk_sync_reg[1:0], tx.MII_Tx_CLK};
  end
  assign tick = clk_sync_reg[1] & ~clk_sync_reg[2];

  // word_reg keeps {last, data}; the reserved FIFO bit is dropped
  assign frame_end = word_reg[8] || (byte_cnt_reg == MAX_CNT);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fcs
      assign fcs_nib[gi] = ~crc_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge System_Clock or posedge Reset) begin
    if (Reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      byte_cnt_reg <= '0;
      crc_reg      <= '0;
      word_reg     <= '0;
      tx_en_reg    <= 1'b0;
      txd_reg      <= '0;
      in_prog_reg  <= 1'b0;
      strobe_reg   <= 1'b0;
      sent_reg     <= 1'b0;
      trunc_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      crc_reg      <= crc_next;
      word_reg     <= word_next;
      strobe_reg   <= strobe_next;
      sent_reg     <= sent_next;
      trunc_reg    <= trunc_next;
      if (tick) begin
        tx_en_reg   <= tx_en_next;
        txd_reg     <= txd_next;
        in_prog_reg <= in_prog_next;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    crc_next      = crc_reg;
    word_next     = word_reg;
    if (tick) begin
      case (state_reg)
        S_IDLE: begin
          if (tx.Transmit_of_Data_RQ) begin
            state_next    = S_PRE;
            cnt_next      = '0;
            byte_cnt_next = '0;
          end
        end
        S_PRE: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == SFD_PREV) crc_next = '1;
          if (cnt_reg == PRE_LAST) begin
            state_next = S_DLO;
            word_next  = {tx.Data_to_Transmit[9], tx.Data_to_Transmit[7:0]};
          end
        end
        S_DLO: begin
          state_next    = S_DHI;
          crc_next      = crc_byte(crc_reg, word_reg[7:0]);
          byte_cnt_next = byte_cnt_reg + 1'b1;
        end
        S_DHI: begin
          cnt_next = '0;
          if (frame_end) begin
            state_next = (byte_cnt_reg < MIN_CNT) ? S_PLO : S_FCS;
          end else begin
            state_next = S_DLO;
            word_next  = {tx.Data_to_Transmit[9], tx.Data_to_Transmit[7:0]};
          end
        end
        S_PLO: begin
          state_next    = S_PHI;
          crc_next      = crc_byte(crc_reg, 8'h00);
          byte_cnt_next = byte_cnt_reg + 1'b1;
        end
        S_PHI: begin
          cnt_next   = '0;
          state_next = (byte_cnt_reg >= MIN_CNT) ? S_FCS : S_PLO;
        end
        S_FCS: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == FCS_LAST) begin
            state_next = S_IFG;
            cnt_next   = '0;
          end
        end
        S_IFG: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == IFG_LAST) begin
            // a pending request starts the preamble on the very next tick
            cnt_next      = '0;
            byte_cnt_next = '0;
            state_next    = tx.Transmit_of_Data_RQ ? S_PRE : S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_en_next  = 1'b1;
    txd_next    = '0;
    strobe_next = 1'b0;
    sent_next   = 1'b0;
    case (state_next)
      S_PRE:        txd_next = (cnt_next == PRE_LAST) ? 4'hD : 4'h5;
      S_DLO:        txd_next = word_next[3:0];
      S_DHI: begin
        txd_next    = word_reg[7:4];
        strobe_next = tick;
      end
      S_PLO, S_PHI: txd_next = '0;
      S_FCS: begin
        txd_next  = fcs_nib[cnt_next[2:0]];
        sent_next = tick && (cnt_next == FCS_LAST);
      end
      default:      tx_en_next = 1'b0;
    endcase
    in_prog_next = tx_en_next;
    trunc_next   = tick && (state_reg == S_DHI) && (byte_cnt_reg == MAX_CNT) && !word_reg[8];
  end

  assign tx.MII_Tx_En          = tx_en_reg;
  assign tx.MII_Tx_Data        = txd_reg;
  assign tx.Eth_Tx_In_Progress = in_prog_reg;
  assign tx.Byte_Readed_Strob  = strobe_reg;
  assign tx.Frame_Sent         = sent_reg;
  assign tx.Tx_Truncated       = trunc_reg;
endmodule

// File: tb/tb_eth_mii_tx_framer.sv
// Directed/random frames through a show-ahead FIFO model; the MII stream is
// compared with a byte-level frame model and the CRC residue.
module tb_eth_mii_tx_framer;
  localparam int MIN_B = 60;
  localparam int MAX_B = 1514;
  localparam int IFG_N = 24;

  logic System_Clock = 1'b0;
  logic Reset;
  logic mii_clk = 1'b0;
  logic rq;
  logic fifo_flush;
  logic [9:0] data_word;

  eth_mii_tx_framer_if bus();
  assign bus.Transmit_of_Data_RQ = rq;
  assign bus.Data_to_Transmit    = data_word;
  assign bus.MII_Tx_CLK          = mii_clk;

  eth_mii_tx_framer #(.MIN_FRAME_BYTES(MIN_B), .MAX_FRAME_BYTES(MAX_B), .IFG_NIBBLES(IFG_N)) dut (
    .System_Clock (System_Clock),
    .Reset        (Reset),
    .tx           (bus.master)
  );

  always #5 System_Clock = ~System_Clock;
  initial begin
    #3;
    forever #20 mii_clk = ~mii_clk;
  end

  // Show-ahead FIFO: word at rd_ptr is always visible, strobe pops it
  logic [9:0] fifo_mem [0:8191];
  int wr_ptr = 0;
  int rd_ptr = 0;
  always @(posedge System_Clock) begin
    if (fifo_flush)                 rd_ptr <= wr_ptr;
    else if (bus.Byte_Readed_Strob) rd_ptr <= rd_ptr + 1;
  end
  assign data_word = fifo_mem[rd_ptr[12:0]];

  // PHY-side capture at the MII rising edge
  logic [3:0] cur_q[$];
  logic [3:0] last_q[$];
  int frames_done = 0, en_rises = 0, en_samples = 0, idle_run = 0, last_gap = -1;
  logic en_prev = 1'b0;
  always @(posedge mii_clk) begin
    if (bus.MII_Tx_En === 1'b1) begin
      if (!en_prev) begin
        en_rises++;
        last_gap = idle_run;
      end
      cur_q.push_back(bus.MII_Tx_Data);
      en_samples++;
    end else begin
      if (en_prev) begin
        last_q = cur_q;
        cur_q.delete();
        frames_done++;
        idle_run = 0;
      end
      idle_run++;
    end
    en_prev = (bus.MII_Tx_En === 1'b1);
  end

  int strobe_cnt = 0, fs_cnt = 0, tr_cnt = 0, tr_at_strobe = 0;
  always @(negedge System_Clock) begin
    if (bus.Byte_Readed_Strob === 1'b1) strobe_cnt++;
    if (bus.Frame_Sent === 1'b1) fs_cnt++;
    if (bus.Tx_Truncated === 1'b1) begin
      tr_cnt++;
      tr_at_strobe = strobe_cnt;
    end
  end

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bit-serial CRC and frame construction from byte lists
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) r = (r >> 1) ^ (((r[0] ^ b[k]) == 1'b1) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  logic [9:0] load_q[$];
  logic [3:0] exp_q[$];
  int exp_reads, exp_trunc, sb_snap;

  task automatic load_frame(input int n, input bit last);
    logic [9:0] w;
    load_q.delete();
    for (int i = 0; i < n; i++) begin
      w = {(last && i == n - 1), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
      fifo_mem[wr_ptr[12:0]] = w;
      wr_ptr++;
      load_q.push_back(w);
    end
  endtask

  task automatic build_expected();
    logic [7:0]  fb[$];
    logic [31:0] c;
    exp_trunc = 0;
    for (int i = 0; i < load_q.size(); i++) begin
      fb.push_back(load_q[i][7:0]);
      if (load_q[i][9]) break;
      if (fb.size() == MAX_B) begin
        exp_trunc = 1;
        break;
      end
    end
    exp_reads = fb.size();
    while (fb.size() < MIN_B) fb.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (fb[i]) c = crc_step(c, fb[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
    exp_q.delete();
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    foreach (fb[i]) begin
      exp_q.push_back(fb[i][3:0]);
      exp_q.push_back(fb[i][7:4]);
    end
  endtask

  task automatic check_frame(input string tag);
    int mism;
    logic [31:0] c;
    mism = 0;
    c = 32'hFFFFFFFF;
    check({tag, "_len"}, 64'(last_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < last_q.size() && i < exp_q.size(); i++)
      if (last_q[i] !== exp_q[i]) mism++;
    check({tag, "_nibbles"}, 64'(mism), 64'd0);
    for (int i = 16; i + 1 < last_q.size(); i += 2) c = crc_step(c, {last_q[i+1], last_q[i]});
    check({tag, "_residue"}, 64'(c), 64'h0DEBB20E3);
  endtask

  task automatic wait_rise(input int target, input string tag);
    int n;
    n = 0;
    while (en_rises < target && n < 5000) begin
      @(negedge System_Clock);
      n++;
    end
    check({tag, "_start"}, 64'(en_rises >= target), 64'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (frames_done < target && n < 20000) begin
      @(negedge System_Clock);
      n++;
    end
    check({tag, "_done"}, 64'(frames_done >= target), 64'd1);
  endtask

  task automatic flush();
    fifo_flush = 1'b1;
    @(negedge System_Clock);
    fifo_flush = 1'b0;
  endtask

  task automatic run_single(input int n, input bit last, input string tag);
    int fd, er, fsb, trb;
    load_frame(n, last);
    build_expected();
    sb_snap = strobe_cnt;
    fsb = fs_cnt;
    trb = tr_cnt;
    fd = frames_done;
    er = en_rises;
    rq = 1'b1;
    wait_rise(er + 1, tag);
    rq = 1'b0;
    wait_done(fd + 1, tag);
    check_frame(tag);
    check({tag, "_strobes"}, 64'(strobe_cnt - sb_snap), 64'(exp_reads));
    check({tag, "_frame_sent"}, 64'(fs_cnt - fsb), 64'd1);
    check({tag, "_truncated"}, 64'(tr_cnt - trb), 64'(exp_trunc));
    $display("frame %s: %0d bytes read, %0d nibbles on wire", tag, strobe_cnt - sb_snap, last_q.size());
  endtask

  initial begin
    int fd, er, fsb, n;
    Reset = 1'b1;
    rq = 1'b0;
    fifo_flush = 1'b0;
    repeat (5) @(negedge System_Clock);
    check("rst_tx_en", 64'(bus.MII_Tx_En), 64'd0);
    check("rst_txd", 64'(bus.MII_Tx_Data), 64'd0);
    check("rst_strobe", 64'(bus.Byte_Readed_Strob), 64'd0);
    check("rst_in_prog", 64'(bus.Eth_Tx_In_Progress), 64'd0);
    check("rst_sent", 64'(bus.Frame_Sent), 64'd0);
    check("rst_trunc", 64'(bus.Tx_Truncated), 64'd0);
    Reset = 1'b0;
    repeat (200) @(negedge System_Clock);
    check("idle_no_tx_en", 64'(en_samples), 64'd0);

    run_single(60, 1'b1, "f60");
    run_single(14, 1'b1, "f14");
    run_single(1600, 1'b0, "trunc");
    check("trunc_at_strobe", 64'(tr_at_strobe - sb_snap), 64'(MAX_B));
    flush();
    run_single(MAX_B, 1'b1, "max_last");

    // Back-to-back: two 100-byte frames with the request held
    load_frame(100, 1'b1);
    load_frame(100, 1'b1);
    build_expected();
    sb_snap = strobe_cnt;
    fsb = fs_cnt;
    fd = frames_done;
    er = en_rises;
    rq = 1'b1;
    wait_rise(er + 2, "b2b");
    rq = 1'b0;
    wait_done(fd + 2, "b2b");
    check_frame("b2b");
    check("b2b_gap", 64'(last_gap), 64'(IFG_N));
    check("b2b_frame_sent", 64'(fs_cnt - fsb), 64'd2);
    check("b2b_strobes", 64'(strobe_cnt - sb_snap), 64'd200);
    $display("frame b2b: gap %0d ticks, %0d bytes read", last_gap, strobe_cnt - sb_snap);

    for (int r = 0; r < 3; r++) run_single($urandom_range(1, 130), 1'b1, $sformatf("rand%0d", r));

    // Reset during data byte 20
    load_frame(60, 1'b1);
    sb_snap = strobe_cnt;
    er = en_rises;
    rq = 1'b1;
    wait_rise(er + 1, "rst_mid");
    rq = 1'b0;
    n = 0;
    while (strobe_cnt - sb_snap < 20 && n < 5000) begin
      @(negedge System_Clock);
      n++;
    end
    check("rst_mid_reached", 64'(strobe_cnt - sb_snap), 64'd20);
    Reset = 1'b1;
    #1;
    check("rst_mid_tx_en", 64'(bus.MII_Tx_En), 64'd0);
    check("rst_mid_in_prog", 64'(bus.Eth_Tx_In_Progress), 64'd0);
    check("rst_mid_txd", 64'(bus.MII_Tx_Data), 64'd0);
    @(negedge System_Clock);
    Reset = 1'b0;
    flush();
    repeat (200) @(negedge System_Clock);
    check("rst_mid_no_resume", 64'(en_rises), 64'(er + 1));
    $display("reset at byte 20: tx_en dropped, no resume");
    run_single(60, 1'b1, "after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
